matrix_random_loader: RTL and testbench

Consumer and controller for the 8-bit LFSR random number generator. On `start`, it drives the generator's `gen_en`, `min_val` and `max_val` inputs and receives `random_out`, `valid` and `range_error` back. It discards the generator's pipeline warm-up samples and writes the remaining samples, in row-major order, into a matrix memory write port. It sits between the top-level matrix controller and the generator.

---
 rtl/matrix_random_loader_pkg.sv | 18 +
 rtl/matrix_random_loader_if.sv | 30 +++
 rtl/matrix_random_loader_checker.sv | 36 +++
 rtl/matrix_random_loader.sv | 219 +++++++++++++++++++++
 tb/tb_matrix_random_loader.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_random_loader_pkg.sv
// Shared definitions for the matrix random loader slice.
//   state_e      : loader FSM states
//   RAND_DISCARD : generator pipeline warm-up samples dropped per fill
//   DATA_W       : generator / matrix data width
package matrix_rand_pkg;

  localparam int DATA_W       = 8;
  localparam int RAND_DISCARD = 2;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/matrix_random_loader_if.sv
// Generator and matrix-write bus of the random loader.
//   master : loader side  (drives gen_en/min_val/max_val and the write port)
//   slave  : generator + matrix memory side
interface matrix_random_loader_if
  import matrix_rand_pkg::*;
#(
  parameter int ADDR_W = 4
);

  logic              gen_en;
  logic [DATA_W-1:0] min_val;
  logic [DATA_W-1:0] max_val;
  logic [DATA_W-1:0] rnd_in;
  logic              rnd_valid;
  logic              rnd_range_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output gen_en, min_val, max_val, wr_en, wr_addr, wr_data,
    input  rnd_in, rnd_valid, rnd_range_err
  );

  modport slave (
    input  gen_en, min_val, max_val, wr_en, wr_addr, wr_data,
    output rnd_in, rnd_valid, rnd_range_err
  );

endinterface

// File: rtl/matrix_random_loader_checker.sv
// rand_sample_checker: range comparator for accepted samples plus a
// saturating violation counter.
//   clk, rst_n   : clock, async active-low reset
//   clear        : zero the counter (new fill accepted)
//   sample_valid : sample is an accepted (non-discarded) one
//   sample       : sample value
//   min_val/max_val : inclusive bounds
//   out_of_range : combinational compare result
//   viol_cnt     : number of out-of-range accepted samples, saturates at 255
module rand_sample_checker
  import matrix_rand_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] min_val,
  input  logic [DATA_W-1:0] max_val,
  output logic              out_of_range,
  output logic [7:0]        viol_cnt
);

  assign out_of_range = (sample < min_val) || (sample > max_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_cnt <= 8'd0;
    end else if (clear) begin
      viol_cnt <= 8'd0;
    end else if (sample_valid && out_of_range && (viol_cnt != 8'hFF)) begin
      viol_cnt <= viol_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/matrix_random_loader.sv
// matrix_random_loader: drives the LFSR generator for one matrix fill,
// drops the generator's warm-up samples and writes the rest row-major
// into the matrix memory write port.
//   clk, rst_n         : clock, async active-low reset
//   start              : fill request (ignored while busy or in DONE)
//   rows_cfg/cols_cfg  : matrix shape, latched on start
//   min_cfg/max_cfg    : sample bounds, latched on start
//   bus (master)       : gen_en/min_val/max_val out, rnd_in/rnd_valid/
//                        rnd_range_err in, wr_en/wr_addr/wr_data out
//   busy, done, error  : status (done pulses, error is sticky until start)
//   viol_cnt           : out-of-range counter, only with MATRIX_RANGE_CHECK_EN
// Optional feature: define MATRIX_RANGE_CHECK_EN to check each accepted
// sample against [min_val, max_val] and abort the fill on a violation.
module matrix_random_loader
  import matrix_rand_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ADDR_W = $clog2(ROWS*COLS)
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(ROWS+1)-1:0]  rows_cfg,
  input  logic [$clog2(COLS+1)-1:0]  cols_cfg,
  input  logic [DATA_W-1:0]          min_cfg,
  input  logic [DATA_W-1:0]          max_cfg,
  matrix_random_loader_if.master     bus,
  output logic                       busy,
  output logic                       done,
  output logic                       error
`ifdef MATRIX_RANGE_CHECK_EN
  ,
  output logic [7:0]                 viol_cnt
`endif
);

  localparam int RW = $clog2(ROWS+1);
  localparam int CW = $clog2(COLS+1);
  localparam int NW = $clog2(ROWS*COLS+1);
  localparam int IW = $clog2(ROWS*COLS+RAND_DISCARD+1);
  localparam int SW = $clog2(RAND_DISCARD+1);

  state_e            state;
  logic [CW-1:0]     cols_q;
  logic [NW-1:0]     n_q;
  logic [IW-1:0]     issue_cnt;
  logic [SW-1:0]     disc_cnt;
  logic [NW-1:0]     wr_idx;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              gen_en_q;
  logic [DATA_W-1:0] min_q, max_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q, done_q, error_q;

  logic [NW-1:0]     n_cfg;
  logic [ADDR_W-1:0] addr_calc;
  logic              active, accept_start, sample_err, keep, do_write, viol;

  assign n_cfg        = NW'(rows_cfg) * NW'(cols_cfg);
  assign addr_calc    = ADDR_W'(row_q) * ADDR_W'(cols_q) + ADDR_W'(col_q);
  assign active       = (state == FILL) || (state == DRAIN);
  assign accept_start = (state == IDLE) && start;
  assign sample_err   = active && bus.rnd_valid && bus.rnd_range_err;
  // Post-warm-up sample that still belongs to this matrix.
  assign keep         = active && bus.rnd_valid && !bus.rnd_range_err &&
                        (disc_cnt == SW'(RAND_DISCARD)) && (wr_idx < n_q);

`ifdef MATRIX_RANGE_CHECK_EN
  logic out_of_range;

  rand_sample_checker u_checker (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (accept_start),
    .sample_valid (keep),
    .sample       (bus.rnd_in),
    .min_val      (min_q),
    .max_val      (max_q),
    .out_of_range (out_of_range),
    .viol_cnt     (viol_cnt)
  );

  assign do_write = keep && !out_of_range;
  assign viol     = keep && out_of_range;
`else
  assign do_write = keep;
  assign viol     = 1'b0;
`endif

  // A generator range error must stop requests in the very cycle it is
  // reported, so the registered enable is gated combinationally here.
  assign bus.gen_en  = gen_en_q && !sample_err;
  assign bus.min_val = min_q;
  assign bus.max_val = max_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

  // NOTE: all state here is flops updated with non-blocking assignments so
  // every read in this block sees the pre-edge value, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cols_q    <= '0;
      n_q       <= '0;
      issue_cnt <= '0;
      disc_cnt  <= '0;
      wr_idx    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      gen_en_q  <= 1'b0;
      min_q     <= '0;
      max_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;

      // Warm-up samples are counted off before any write is allowed.
      if (active && bus.rnd_valid && !bus.rnd_range_err &&
          (disc_cnt != SW'(RAND_DISCARD))) begin
        disc_cnt <= disc_cnt + SW'(1);
      end

      if (do_write) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= addr_calc;
        wr_data_q <= bus.rnd_in;
        wr_idx    <= wr_idx + NW'(1);
        if (col_q == cols_q - CW'(1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            cols_q    <= cols_cfg;
            n_q       <= n_cfg;
            min_q     <= min_cfg;
            max_q     <= max_cfg;
            error_q   <= 1'b0;
            issue_cnt <= '0;
            disc_cnt  <= '0;
            wr_idx    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            if (n_cfg == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (max_cfg < min_cfg) begin
              state   <= ERR;
              busy_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state    <= FILL;
              busy_q   <= 1'b1;
              gen_en_q <= 1'b1;
            end
          end
        end

        FILL: begin
          issue_cnt <= issue_cnt + IW'(1);
          if (sample_err || viol) begin
            state    <= ERR;
            gen_en_q <= 1'b0;
            error_q  <= 1'b1;
          end else if (issue_cnt == IW'(n_q) + IW'(RAND_DISCARD - 1)) begin
            state    <= DRAIN;
            gen_en_q <= 1'b0;
          end
        end

        DRAIN: begin
          if (sample_err || viol) begin
            state   <= ERR;
            error_q <= 1'b1;
          end else if (wr_en_q && (wr_idx == n_q)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        ERR: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          gen_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_random_loader.sv
// Self-checking bench for matrix_random_loader. A generator stub answers
// each gen_en cycle with one valid sample on the following cycle; a
// per-cycle expectation table is built from the fill timing rules and
// every cycle of each scenario is compared against it.
module tb_matrix_random_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] rows_cfg, cols_cfg;
  logic [7:0] min_cfg, max_cfg;
  logic       busy, done, error;
`ifdef MATRIX_RANGE_CHECK_EN
  logic [7:0] viol_cnt;
`endif

  matrix_random_loader_if #(.ADDR_W(4)) bus ();

  matrix_random_loader #(.ROWS(4), .COLS(4), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rows_cfg (rows_cfg),
    .cols_cfg (cols_cfg),
    .min_cfg  (min_cfg),
    .max_cfg  (max_cfg),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error)
`ifdef MATRIX_RANGE_CHECK_EN
    ,
    .viol_cnt (viol_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected outputs per cycle after start (cycle 0 = start cycle).
  int exp_gen [64];
  int exp_wr  [64];
  int exp_addr[64];
  int exp_data[64];
  int exp_busy[64];
  int exp_done[64];
  int exp_err [64];   // -1 = not compared in that cycle
  int last_cycle;

  // Observations used to pin the model with hand-computed literals.
  int   done_at;
  int   gen_seen;
  int   wq[$];
  int   dq[$];
  logic force_99 = 1'b0;

  task automatic check(input string name, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  function automatic int gen_data(input int k, input int mn, input int mx);
    return mn + ((k*7 + 3) % (mx - mn + 1));
  endfunction

  // Expectations from the fill rules: requests in cycles 1..N+2, sample k
  // arrives in cycle k+1, samples 1..2 are dropped, sample k>=3 is written
  // in cycle k+2 at address k-3, done in cycle N+5. A range error on valid
  // e gates gen_en from cycle e+1, ERR occupies cycle e+2.
  task automatic build_model(input int rows, input int cols, input int mn,
                             input int mx, input int err_at);
    int n, gen_last, k_last;
    n = rows * cols;
    for (int c = 0; c < 64; c++) begin
      exp_gen[c] = 0; exp_wr[c] = 0; exp_addr[c] = 0; exp_data[c] = 0;
      exp_busy[c] = 0; exp_done[c] = 0;
      exp_err[c] = (c == 0) ? -1 : 0;
    end
    if (n == 0) begin
      exp_done[1] = 1;
      last_cycle  = 3;
    end else if (mx < mn) begin
      exp_busy[1] = 1;
      exp_err[1]  = -1;
      for (int c = 2; c < 64; c++) exp_err[c] = 1;
      last_cycle = 3;
    end else begin
      gen_last = (err_at != 0 && err_at < n + 2) ? err_at : n + 2;
      k_last   = (err_at != 0) ? err_at - 1 : n + 2;
      for (int c = 1; c <= gen_last; c++) exp_gen[c] = 1;
      for (int k = 3; k <= k_last; k++) begin
        exp_wr[k+2]   = 1;
        exp_addr[k+2] = k - 3;
        exp_data[k+2] = gen_data(k, mn, mx);
      end
      if (err_at != 0) begin
        for (int c = 1; c <= err_at + 2; c++) exp_busy[c] = 1;
        exp_err[err_at+2] = -1;
        for (int c = err_at + 3; c < 64; c++) exp_err[c] = 1;
        last_cycle = err_at + 4;
      end else begin
        for (int c = 1; c <= n + 4; c++) exp_busy[c] = 1;
        exp_done[n+5] = 1;
        last_cycle = n + 7;
      end
    end
  endtask

  task automatic compare_cycle(input int c, input int mn, input int mx);
    check("gen_en", c, 32'(bus.gen_en), 32'(exp_gen[c]));
    check("wr_en",  c, 32'(bus.wr_en),  32'(exp_wr[c]));
    check("busy",   c, 32'(busy),       32'(exp_busy[c]));
    check("done",   c, 32'(done),       32'(exp_done[c]));
    if (exp_wr[c] != 0) begin
      check("wr_addr", c, 32'(bus.wr_addr), 32'(exp_addr[c]));
      check("wr_data", c, 32'(bus.wr_data), 32'(exp_data[c]));
    end
    if (exp_err[c] >= 0) check("error", c, 32'(error), 32'(exp_err[c]));
    if (c >= 1) begin
      check("min_val", c, 32'(bus.min_val), 32'(mn));
      check("max_val", c, 32'(bus.max_val), 32'(mx));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gen_en"},  0, 32'(bus.gen_en),  32'd0);
    check({tag, "_wr_en"},   0, 32'(bus.wr_en),   32'd0);
    check({tag, "_wr_addr"}, 0, 32'(bus.wr_addr), 32'd0);
    check({tag, "_wr_data"}, 0, 32'(bus.wr_data), 32'd0);
    check({tag, "_min_val"}, 0, 32'(bus.min_val), 32'd0);
    check({tag, "_max_val"}, 0, 32'(bus.max_val), 32'd0);
    check({tag, "_busy"},    0, 32'(busy),        32'd0);
    check({tag, "_done"},    0, 32'(done),        32'd0);
    check({tag, "_error"},   0, 32'(error),       32'd0);
  endtask

  // Runs one fill. extra_start: cycle with a second start pulse (-1 none);
  // rst_cycle: cycle in which rst_n is pulled low mid-cycle (-1 none).
  task automatic run_fill(input int rows, input int cols, input int mn,
                          input int mx, input int err_at,
                          input int extra_start, input int rst_cycle);
    int   vcount;
    logic gen_prev;
    build_model(rows, cols, mn, mx, err_at);
    vcount = 0; gen_prev = 1'b0; done_at = -1; gen_seen = 0;
    wq.delete(); dq.delete();
    rows_cfg = 3'(rows); cols_cfg = 3'(cols);
    min_cfg  = 8'(mn);   max_cfg  = 8'(mx);
    for (int c = 0; c <= last_cycle; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == extra_start);
      if (gen_prev) begin
        vcount++;
        bus.rnd_valid     = 1'b1;
        bus.rnd_in        = 8'(gen_data(vcount, mn, mx));
        bus.rnd_range_err = (vcount == err_at);
      end else begin
        bus.rnd_valid     = 1'b0;
        bus.rnd_in        = 8'd0;
        bus.rnd_range_err = 1'b0;
      end
      #1;
      compare_cycle(c, mn, mx);
      if (bus.wr_en) begin
        wq.push_back(int'(bus.wr_addr));
        dq.push_back(int'(bus.wr_data));
      end
      if (done) done_at = c;
      if (bus.gen_en) gen_seen++;
      gen_prev = bus.gen_en;
      if (c == rst_cycle) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midfill_rst");
        break;
      end
    end
    start = 1'b0;
    bus.rnd_valid = 1'b0; bus.rnd_in = 8'd0; bus.rnd_range_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0;
    rows_cfg = '0; cols_cfg = '0; min_cfg = '0; max_cfg = '0;
    bus.rnd_valid = 1'b0; bus.rnd_in = 8'd0; bus.rnd_range_err = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2 fill, second start in the done cycle must be ignored.
    run_fill(2, 2, 10, 20, 0, 9, -1);
    check("p2x2_done_cycle", 0, 32'(done_at),   32'd9);
    check("p2x2_gen_cycles", 0, 32'(gen_seen),  32'd6);
    check("p2x2_num_writes", 0, 32'(wq.size()), 32'd4);
    if (wq.size() == 4) begin
      for (int i = 0; i < 4; i++) check("p2x2_addr", i, 32'(wq[i]), 32'(i));
      check("p2x2_data0", 0, 32'(dq[0]), 32'd12);
      check("p2x2_data3", 3, 32'(dq[3]), 32'd11);
    end

    // Inverted bounds: ERR for one cycle, nothing issued.
    run_fill(1, 1, 50, 40, 0, -1, -1);
    check("badrange_writes", 0, 32'(wq.size()), 32'd0);

    // Empty matrix (also clears the error left by the previous test).
    run_fill(0, 3, 0, 255, 0, -1, -1);
    check("empty_done_cycle", 0, 32'(done_at),  32'd1);
    check("empty_gen",        0, 32'(gen_seen), 32'd0);

    // Range error on the 4th valid of a 3x3 fill.
    run_fill(3, 3, 0, 255, 4, -1, -1);
    check("rerr_writes", 0, 32'(wq.size()), 32'd1);
    if (wq.size() == 1) check("rerr_addr", 0, 32'(wq[0]), 32'd0);
    check("rerr_no_done", 0, 32'(done_at), 32'hFFFF_FFFF);

    // Degenerate range and a full-size matrix.
    run_fill(2, 3, 100, 100, 0, -1, -1);
    run_fill(4, 4, 0, 255, 0, -1, -1);
    check("full_num_writes", 0, 32'(wq.size()), 32'd16);
    if (wq.size() == 16) check("full_last_addr", 15, 32'(wq[15]), 32'd15);

    // Reset during the cycle-6 write of a 4x4 fill, then a 1x1 fill.
    run_fill(4, 4, 0, 255, 0, -1, 6);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_fill(1, 1, 3, 200, 0, -1, -1);
    check("post_rst_done_cycle", 0, 32'(done_at), 32'd6);

`ifdef MATRIX_RANGE_CHECK_EN
    begin
      int wr_seen = 0;
      rows_cfg = 3'd1; cols_cfg = 3'd1; min_cfg = 8'd0; max_cfg = 8'd9;
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        start = (c == 0);
        bus.rnd_valid = force_99;
        bus.rnd_in    = 8'd99;
        #1;
        force_99 = bus.gen_en;
        if (bus.wr_en) wr_seen++;
      end
      start = 1'b0; bus.rnd_valid = 1'b0;
      check("viol_writes", 0, 32'(wr_seen),  32'd0);
      check("viol_cnt",    0, 32'(viol_cnt), 32'd1);
      check("viol_error",  0, 32'(error),    32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
